// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channel between the core's fetch unit (master)
// and the instruction-memory responder (slave).
interface imem_fetch_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency read pipeline feeding an
// in-order response FIFO, with credit-based request throttling and flush.
module imem_fetch_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  imem_fetch_responder_if.slave    bus,
  input  logic                     flush_i,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [31:0]              ld_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   Credits = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

  logic [31:0]         mem_q [DEPTH];

  logic [LATENCY-1:0]  pv_q;
  logic [31:0]         pa_q [LATENCY];
  logic [31:0]         pd_q [LATENCY];
  logic [LATENCY-1:0]  pe_q;

  logic [31:0]         fa_q [FIFO_DEPTH];
  logic [31:0]         fd_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fe_q;
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, infl_q;

  logic          accept, push, pop, req_err;
  logic [AW-1:0] req_idx;
  logic [CW:0]   used;

  assign req_err = (|bus.req_addr[1:0]) || (|bus.req_addr[31:AW+2]);
  assign req_idx = bus.req_addr[AW+1:2];

  // Credits cover both pipeline occupants and buffered words, so the FIFO
  // can never be pushed while full.
  assign used          = {1'b0, infl_q} + {1'b0, cnt_q};
  assign bus.req_ready = !flush_i && (used < Credits);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = pv_q[LATENCY-1];
  assign bus.rsp_valid = (cnt_q != '0) && !flush_i;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    bus.rsp_data = '0;
    bus.rsp_addr = '0;
    bus.rsp_err  = 1'b0;
    if (cnt_q != '0) begin
      bus.rsp_data = fd_q[rd_q];
      bus.rsp_addr = fa_q[rd_q];
      bus.rsp_err  = fe_q[rd_q];
    end
  end

  // Program store: not reset; a same-edge load is invisible to the fetch.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept && !flush_i;
      if (accept) begin
        pa_q[0] <= bus.req_addr;
        pe_q[0] <= req_err;
        pd_q[0] <= req_err ? 32'h0 : mem_q[req_idx];
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1] && !flush_i;
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fa_q[wr_q] <= pa_q[LATENCY-1];
      fd_q[wr_q] <= pd_q[LATENCY-1];
      fe_q[wr_q] <= pe_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else if (flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      wr_q   <= wr_q + PW'(push);
      rd_q   <= rd_q + PW'(pop);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      infl_q <= infl_q + CW'(accept) - CW'(push);
    end
  end

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !flush_i) |-> (cnt_q != FullCnt));
`endif

endmodule
